quad_decoder_mod_n: RTL and testbench
=====================================

# quad_decoder_mod_n

Quadrature (A/B) decoder that turns a two-phase Gray-coded input into a mod-N position count with direction and step outputs. It is the receive side of the up/down counter interface: it derives up/down intent from an external incremental encoder and keeps the wrapping position locally. It sits directly behind asynchronous encoder pins and feeds position and step pulses to downstream control logic.

## Interface
- `N`, 10, modulus; position range 0..N-1; N >= 2.
- `W`, 4, position width; N <= 2^W required.

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `a_in`  in  1  encoder phase A; asynchronous.
- `b_in`  in  1  encoder phase B; asynchronous.
- `idx_in`  in  1  encoder index; asynchronous; present only with `QDEC_INDEX_EN`.
- `clr`  in  1  synchronous position clear.
- `err_clr`  in  1  clears sticky error.
- `pos`  out  W  current position, 0..N-1.
- `dir`  out  1  direction of last counted step; 1 = up.
- `step`  out  1  one-cycle pulse per counted step.
- `err`  out  1  sticky illegal-transition flag.

## Operation
- Synchronizer: 2-flop chain per asynchronous input; the second stage output is `cur_ab` = {A,B}.
- `prev_ab` register holds the last accepted `cur_ab`.
- FSM states:
  - INIT: entered on reset and lasts 3 cycles (2 for sync fill, 1 to load `prev_ab <= cur_ab`). No counting, no `step`, no `err`.
  - RUN: decodes on every cycle. Never returns to INIT except via `rst`.
- Decode in RUN, {prev → cur}:
  - Up: 00→01, 01→11, 11→10, 10→00.
  - Down: 01→00, 11→01, 10→11, 00→10.
  - Equal: no action.
  - Both bits changed: illegal; set `err`; no count, no `step`.
- `prev_ab <= cur_ab` every RUN cycle, including illegal transitions, so the decoder resynchronizes.
- Counting is 4x: every legal edge counts.
  - Up: `pos` = N-1 wraps to 0, else `pos` + 1.
  - Down: `pos` = 0 wraps to N-1, else `pos` - 1.
  - On each counted step: `dir` <= 1 for up, 0 for down; `step` = 1 for that cycle.
  - Arithmetic is W bits wide, with explicit compare against N-1. No reliance on natural overflow.
- Priority on `pos`: `rst` > `clr` (> index load) > count.
  - `clr` with a coincident count: `pos` <= 0, `step` = 0, `dir` unchanged, count dropped.
- `err`:
  - Set by an illegal transition.
  - Cleared by `err_clr` only.
  - Set wins over a simultaneous `err_clr`.
- Reset values: `pos` = 0, `dir` = 1, `step` = 0, `err` = 0, sync flops = 0, `prev_ab` = 00, state INIT.

## Timing
- An input level present at rising edge k appears on `cur_ab` after edge k+1. `pos`, `dir` and `step` update at edge k+2, giving 3-edge latency.
- `step` is high for exactly one cycle per counted edge. Back-to-back legal edges on consecutive cycles give consecutive `step` pulses.
- Inputs must be stable for at least 1 clk period between edges; faster edges can appear as illegal transitions.
- `rst` mid-operation: all outputs take reset values at that edge. Counting resumes 3 cycles after `rst` deasserts, from whatever level the pins then hold, with no spurious count.
- `clr` takes effect at the edge where it is sampled high.

## Configuration
- `QDEC_INDEX_EN` defined:
  - `idx_in` port exists and gets its own 2-flop synchronizer plus an edge detector.
  - A rising edge of the synchronized index loads `pos` <= 0 on the same edge the decode would act (3-edge latency from pin), with no `step`.
  - Index load overrides a coincident count; with `clr` the result is 0 either way.
- `QDEC_INDEX_EN` undefined: no `idx_in` port and no index logic; `pos` changes only by count, `clr`, or `rst`.

## Test plan
- Reset, then hold 00 for 4 cycles, then 8 up edges (00,01,11,10,…) spaced 4 cycles apart with N=10 → `pos` 0→8, 8 `step` pulses, `dir`=1, `err`=0.
- Wrap: at `pos`=9 one up edge → `pos`=0. Then one down edge → `pos`=9, `dir`=0, one `step` each.
- Illegal 00→11 → `err`=1, `pos` unchanged, no `step`. Pulse `err_clr` → `err`=0. Illegal edge coincident with `err_clr` → `err`=1.
- At `pos`=5, `clr` asserted on the same edge an up count lands → `pos`=0, `step`=0, `dir` unchanged.
- At `pos`=7, assert `rst` for 1 cycle with pins held at 11 → `pos`=0, `dir`=1 immediately. No count during or after INIT. Next up edge 11→10 → `pos`=1.
- With `QDEC_INDEX_EN`: at `pos`=6, pulse `idx_in` high for 3 cycles → `pos`=0 three edges after the rising edge, no `step`. Rebuild without the macro: same bench minus the index stimulus passes.

Source files
------------

// File: rtl/quad_decoder_mod_n_if.sv
// Signal bundle between a quadrature decoder and its environment.
// With QDEC_INDEX_EN defined the bundle also carries the encoder index pin.
interface quad_decoder_mod_n_if #(
  parameter int unsigned W = 4
) ();
  logic         a_in;
  logic         b_in;
`ifdef QDEC_INDEX_EN
  logic         idx_in;
`endif
  logic         clr;
  logic         err_clr;
  logic [W-1:0] pos;
  logic         dir;
  logic         step;
  logic         err;

  modport master (
`ifdef QDEC_INDEX_EN
    output idx_in,
`endif
    output a_in, b_in, clr, err_clr,
    input  pos, dir, step, err
  );

  modport slave (
`ifdef QDEC_INDEX_EN
    input  idx_in,
`endif
    input  a_in, b_in, clr, err_clr,
    output pos, dir, step, err
  );
endinterface

// File: rtl/quad_decoder_mod_n.sv
// Quadrature A/B decoder with a wrapping mod-N position, direction, step pulse and sticky error.
// Define QDEC_INDEX_EN to add the index input that zeroes the position on its rising edge.
module quad_decoder_mod_n #(
  parameter int unsigned N = 10,
  parameter int unsigned W = 4
) (
  input  logic                clk,
  input  logic                rst,
  quad_decoder_mod_n_if.slave bus
);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_e;

  localparam logic [W-1:0] POS_MAX = W'(N - 1);

  logic [1:0]   a_sync_q, b_sync_q;
  logic [1:0]   cur_ab;
  logic [1:0]   prev_ab_q;
  state_e       state_q, state_d;
  logic [1:0]   init_cnt_q, init_cnt_d;
  logic [W-1:0] pos_q, pos_d;
  logic         dir_q, dir_d;
  logic         step_q, step_d;
  logic         err_q, err_d;
  logic         step_up, step_dn, illegal;
  logic         idx_rise;

  assign cur_ab = {a_sync_q[1], b_sync_q[1]};

`ifdef QDEC_INDEX_EN
  logic [1:0] idx_sync_q;
  logic       idx_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_sync_q <= 2'b00;
      idx_prev_q <= 1'b0;
    end else begin
      idx_sync_q <= {idx_sync_q[0], bus.idx_in};
      idx_prev_q <= idx_sync_q[1];
    end
  end

  assign idx_rise = idx_sync_q[1] & ~idx_prev_q;
`else
  assign idx_rise = 1'b0;
`endif

  // Gray-code step classification of the last accepted level against the new one.
  always_comb begin
    step_up = 1'b0;
    step_dn = 1'b0;
    unique case ({prev_ab_q, cur_ab})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_up = 1'b1;
      4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: step_dn = 1'b1;
      default: ;
    endcase
    illegal = ((prev_ab_q ^ cur_ab) == 2'b11);
  end

  always_comb begin
    // NOTE: every variable gets its default first so no path can infer a latch.
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    pos_d      = pos_q;
    dir_d      = dir_q;
    step_d     = 1'b0;
    err_d      = err_q;

    if (bus.err_clr) err_d = 1'b0;

    unique case (state_q)
      S_INIT: begin
        // Two cycles fill the synchronizers, the third settles prev_ab on the pin level.
        if (init_cnt_q == 2'd2) state_d = S_RUN;
        else                    init_cnt_d = init_cnt_q + 2'd1;
      end
      S_RUN: begin
        if (illegal) err_d = 1'b1;
        if (step_up) begin
          pos_d  = (pos_q == POS_MAX) ? '0 : pos_q + W'(1);
          dir_d  = 1'b1;
          step_d = 1'b1;
        end else if (step_dn) begin
          pos_d  = (pos_q == '0) ? POS_MAX : pos_q - W'(1);
          dir_d  = 1'b0;
          step_d = 1'b1;
        end
        if (idx_rise) begin
          pos_d  = '0;
          dir_d  = dir_q;
          step_d = 1'b0;
        end
      end
      default: state_d = S_INIT;
    endcase

    if (bus.clr) begin
      pos_d  = '0;
      dir_d  = dir_q;
      step_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the synchronizer flops are reset too, so INIT always starts from a known pipeline.
    if (rst) begin
      a_sync_q   <= 2'b00;
      b_sync_q   <= 2'b00;
      prev_ab_q  <= 2'b00;
      state_q    <= S_INIT;
      init_cnt_q <= 2'd0;
      pos_q      <= '0;
      dir_q      <= 1'b1;
      step_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      a_sync_q   <= {a_sync_q[0], bus.a_in};
      b_sync_q   <= {b_sync_q[0], bus.b_in};
      prev_ab_q  <= cur_ab;
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      pos_q      <= pos_d;
      dir_q      <= dir_d;
      step_q     <= step_d;
      err_q      <= err_d;
    end
  end

  assign bus.pos  = pos_q;
  assign bus.dir  = dir_q;
  assign bus.step = step_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_quad_decoder_mod_n.sv
// Directed bench for quad_decoder_mod_n (N=10, W=4): vector table plus corner-case sequences.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_quad_decoder_mod_n;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_cnt = 0;

  always #5 clk = ~clk;

  quad_decoder_mod_n_if #(.W(4)) bus ();

  quad_decoder_mod_n #(.N(10), .W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(negedge clk) if (bus.step === 1'b1) step_cnt++;

  typedef struct packed {
    logic [1:0] ab;
    logic       err_clr;
    logic [3:0] pos;
    logic       dir;
    logic [1:0] steps;
    logic       err;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ab(input logic [1:0] ab);
    bus.a_in = ab[1];
    bus.b_in = ab[0];
  endtask

  task automatic move(input logic [1:0] ab);
    set_ab(ab);
    tick(4);
  endtask

  int base;

  initial begin
    // Eight up edges, wrap up, wrap down, illegal, error clear, wrap up again.
    vecs[0]  = '{2'b01, 1'b0, 4'd1, 1'b1, 2'd1, 1'b0};
    vecs[1]  = '{2'b11, 1'b0, 4'd2, 1'b1, 2'd1, 1'b0};
    vecs[2]  = '{2'b10, 1'b0, 4'd3, 1'b1, 2'd1, 1'b0};
    vecs[3]  = '{2'b00, 1'b0, 4'd4, 1'b1, 2'd1, 1'b0};
    vecs[4]  = '{2'b01, 1'b0, 4'd5, 1'b1, 2'd1, 1'b0};
    vecs[5]  = '{2'b11, 1'b0, 4'd6, 1'b1, 2'd1, 1'b0};
    vecs[6]  = '{2'b10, 1'b0, 4'd7, 1'b1, 2'd1, 1'b0};
    vecs[7]  = '{2'b00, 1'b0, 4'd8, 1'b1, 2'd1, 1'b0};
    vecs[8]  = '{2'b01, 1'b0, 4'd9, 1'b1, 2'd1, 1'b0};
    vecs[9]  = '{2'b11, 1'b0, 4'd0, 1'b1, 2'd1, 1'b0};
    vecs[10] = '{2'b01, 1'b0, 4'd9, 1'b0, 2'd1, 1'b0};
    vecs[11] = '{2'b10, 1'b0, 4'd9, 1'b0, 2'd0, 1'b1};
    vecs[12] = '{2'b10, 1'b1, 4'd9, 1'b0, 2'd0, 1'b0};
    vecs[13] = '{2'b00, 1'b0, 4'd0, 1'b1, 2'd1, 1'b0};

    rst         = 1'b1;
    bus.a_in    = 1'b0;
    bus.b_in    = 1'b0;
    bus.clr     = 1'b0;
    bus.err_clr = 1'b0;
`ifdef QDEC_INDEX_EN
    bus.idx_in  = 1'b0;
`endif
    tick(2);
    check("reset_pos",  32'(bus.pos),  0);
    check("reset_dir",  32'(bus.dir),  1);
    check("reset_step", 32'(bus.step), 0);
    check("reset_err",  32'(bus.err),  0);
    rst = 1'b0;
    tick(4);
    check("init_no_count", step_cnt, 0);

    for (int i = 0; i < 14; i++) begin
      base = step_cnt;
      set_ab(vecs[i].ab);
      bus.err_clr = vecs[i].err_clr;
      tick(4);
      bus.err_clr = 1'b0;
      check($sformatf("vec%0d_pos", i),   32'(bus.pos), 32'(vecs[i].pos));
      check($sformatf("vec%0d_dir", i),   32'(bus.dir), 32'(vecs[i].dir));
      check($sformatf("vec%0d_err", i),   32'(bus.err), 32'(vecs[i].err));
      check($sformatf("vec%0d_steps", i), step_cnt - base, 32'(vecs[i].steps));
    end

    // Illegal 00->11 landing on the same edge as err_clr: set wins.
    base = step_cnt;
    set_ab(2'b11);
    tick(2);
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    check("illegal_vs_clr_err", 32'(bus.err), 1);
    check("illegal_pos",        32'(bus.pos), 0);
    tick(1);
    check("illegal_steps", step_cnt - base, 0);
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    check("err_clr_pulse", 32'(bus.err), 0);

    // Reach pos 5 with dir=0, then clr coincides with an up count.
    move(2'b10); move(2'b00); move(2'b01); move(2'b11); move(2'b10); move(2'b00);
    check("up_to_6", 32'(bus.pos), 6);
    move(2'b10);
    check("down_to_5_pos", 32'(bus.pos), 5);
    check("down_to_5_dir", 32'(bus.dir), 0);
    base = step_cnt;
    set_ab(2'b00);
    tick(2);
    bus.clr = 1'b1;
    tick(1);
    bus.clr = 1'b0;
    check("clr_pos",  32'(bus.pos),  0);
    check("clr_dir",  32'(bus.dir),  0);
    check("clr_step", 32'(bus.step), 0);
    tick(1);
    check("clr_steps", step_cnt - base, 0);
    tick(2);

    // Reach pos 7 with dir=0, then reset while pins move to 11.
    move(2'b01); move(2'b11); move(2'b10); move(2'b00);
    move(2'b01); move(2'b11); move(2'b10); move(2'b00);
    check("up_to_8", 32'(bus.pos), 8);
    move(2'b10);
    check("pre_rst_pos", 32'(bus.pos), 7);
    check("pre_rst_dir", 32'(bus.dir), 0);
    set_ab(2'b11);
    rst = 1'b1;
    tick(1);
    check("midrst_pos",  32'(bus.pos),  0);
    check("midrst_dir",  32'(bus.dir),  1);
    check("midrst_step", 32'(bus.step), 0);
    check("midrst_err",  32'(bus.err),  0);
    rst  = 1'b0;
    base = step_cnt;
    tick(6);
    check("post_rst_pos",   32'(bus.pos), 0);
    check("post_rst_steps", step_cnt - base, 0);
    move(2'b10);
    check("post_rst_up_pos", 32'(bus.pos), 1);
    check("post_rst_up_dir", 32'(bus.dir), 1);

    // Legal edges on consecutive cycles give consecutive step pulses.
    set_ab(2'b00);
    tick(1);
    set_ab(2'b01);
    tick(1);
    set_ab(2'b11);
    tick(1);
    check("b2b_step0", 32'(bus.step), 1);
    check("b2b_pos0",  32'(bus.pos),  2);
    tick(1);
    check("b2b_step1", 32'(bus.step), 1);
    check("b2b_pos1",  32'(bus.pos),  3);
    tick(1);
    check("b2b_step2", 32'(bus.step), 1);
    check("b2b_pos2",  32'(bus.pos),  4);
    tick(1);
    check("b2b_step3", 32'(bus.step), 0);
    check("b2b_err",   32'(bus.err),  0);
    tick(2);

`ifdef QDEC_INDEX_EN
    // Index held 3 cycles at pos 6: single load to 0, three edges after it rises.
    move(2'b10); move(2'b00);
    check("idx_pre_pos", 32'(bus.pos), 6);
    base = step_cnt;
    bus.idx_in = 1'b1;
    tick(2);
    check("idx_early_pos", 32'(bus.pos), 6);
    tick(1);
    bus.idx_in = 1'b0;
    check("idx_pos",  32'(bus.pos),  0);
    check("idx_step", 32'(bus.step), 0);
    tick(3);
    check("idx_steps",    step_cnt - base, 0);
    check("idx_hold_pos", 32'(bus.pos), 0);
    move(2'b01);
    check("idx_then_up", 32'(bus.pos), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
